// File: rtl/tap_delay_line_if.sv
// Bus bundle for tap_delay_line: shift/clear controls in, parallel taps and
// the selected delayed sample out. Clock and reset stay plain module ports.
interface tap_delay_line_if #(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int CH = 1
);
  localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(N + 1);

  logic                  clr;
  logic                  in_valid;
  logic [CH*W-1:0]       in_data;
  logic [SW-1:0]         sel;
  logic [CH*N*W-1:0]     taps;
  logic [CH*W-1:0]       out_data;
  logic                  out_valid;
  logic [FW-1:0]         fill;
  logic                  full;

  modport master (
    output clr, in_valid, in_data, sel,
    input  taps, out_data, out_valid, fill, full
  );

  modport slave (
    input  clr, in_valid, in_data, sel,
    output taps, out_data, out_valid, fill, full
  );
endinterface

// File: rtl/tap_delay_line.sv
// Multi-channel N-deep tap delay line: parallel tap bus for the MAC stage plus a
// registered, clamped tap select whose valid flag waits until the tap is filled.
module tap_delay_line #(
  parameter int N   = 8,
  parameter int W   = 16,
  parameter int CH  = 1,
  parameter int DIR = 0
) (
  input  logic             clk,
  input  logic             rst,
  tap_delay_line_if.slave  bus
);
  localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(N + 1);
  localparam logic [SW-1:0] SEL_MAX  = SW'(N - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);

  // taps_q[c][k]: channel c, tap k (k = 0 is the newest sample)
  logic [CH-1:0][N-1:0][W-1:0] taps_q, taps_d;
  logic [CH*W-1:0]             out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [SW-1:0]               sel_eff;

  // Out-of-range selects land on the oldest tap instead of indexing past the array.
  always_comb begin
    sel_eff = (bus.sel > SEL_MAX) ? SEL_MAX : bus.sel;
  end

  // NOTE: every signal gets a default at the top of always_comb, so no path can leave one unassigned and infer a latch.
  always_comb begin
    taps_d      = taps_q;
    out_data_d  = out_data_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;

    if (bus.clr) begin
      taps_d     = '0;
      out_data_d = '0;
      fill_d     = '0;
    end else if (bus.in_valid) begin
      for (int c = 0; c < CH; c++) begin
        taps_d[c][0] = bus.in_data[c*W +: W];
        for (int k = 1; k < N; k++) begin
          taps_d[c][k] = taps_q[c][k-1];
        end
      end
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
      for (int c = 0; c < CH; c++) begin
        out_data_d[c*W +: W] = taps_d[c][sel_eff];
      end
      // A tap holds real data only once more samples have arrived than its delay.
      out_valid_d = (32'(fill_d) > 32'(sel_eff));
    end
  end

  // NOTE: the tap array is reset like ordinary state because the MAC stage reads it directly and must see zeros, not X.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      fill_q      <= '0;
    end else begin
      taps_q      <= taps_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      fill_q      <= fill_d;
    end
  end

  // DIR only reorders words on the bus; storage is always tap-indexed.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar k = 0; k < N; k++) begin : g_tap
      localparam int J = (DIR != 0) ? (N - 1 - k) : k;
      assign bus.taps[(c*N + J)*W +: W] = taps_q[c][k];
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fill      = fill_q;
  assign bus.full      = (fill_q == FILL_MAX);
endmodule

// File: tb/tb_tap_delay_line.sv
// Two tap_delay_line instances (power-of-two and clamping geometries, both bus
// orders) driven in lockstep and compared against a sample-history model.
module tb_tap_delay_line;
  typedef logic [63:0]  vec_t;
  typedef logic [383:0] big_t;

  // geometry of instance 0 (a) and instance 1 (b)
  localparam int NA = 8, WA = 16, CA = 3, DA = 0;
  localparam int NB = 5, WB = 12, CB = 2, DB = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic [2:0]   sel = '0;
  logic [CA*WA-1:0] data_a = '0;
  logic [CB*WB-1:0] data_b = '0;

  int n_checks = 0;
  int n_errors = 0;

  // model: every sample accepted since the last clear/reset, in arrival order
  vec_t samp [2][4096];
  int   cnt  [2];
  vec_t od   [2];
  logic ov   [2];

  always #5 clk = ~clk;

  tap_delay_line_if #(.N(NA), .W(WA), .CH(CA)) if_a ();
  tap_delay_line_if #(.N(NB), .W(WB), .CH(CB)) if_b ();

  assign if_a.clr = clr;  assign if_a.in_valid = in_valid;
  assign if_a.sel = sel;  assign if_a.in_data  = data_a;
  assign if_b.clr = clr;  assign if_b.in_valid = in_valid;
  assign if_b.sel = sel;  assign if_b.in_data  = data_b;

  tap_delay_line #(.N(NA), .W(WA), .CH(CA), .DIR(DA)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  tap_delay_line #(.N(NB), .W(WB), .CH(CB), .DIR(DB)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  task automatic check(input string tag, input big_t got, input big_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int geo_n(input int d); return (d == 0) ? NA : NB; endfunction
  function automatic int geo_w(input int d); return (d == 0) ? WA : WB; endfunction
  function automatic int geo_c(input int d); return (d == 0) ? CA : CB; endfunction
  function automatic int geo_dir(input int d); return (d == 0) ? DA : DB; endfunction

  // sample accepted k shifts ago (all channels), zero if none yet
  function automatic vec_t tap_of(input int d, input int k);
    return (k < cnt[d]) ? samp[d][cnt[d]-1-k] : '0;
  endfunction

  function automatic big_t exp_taps(input int d);
    big_t bus_v = '0;
    big_t word;
    int n = geo_n(d), w = geo_w(d);
    for (int c = 0; c < geo_c(d); c++) begin
      for (int k = 0; k < n; k++) begin
        int j = (geo_dir(d) != 0) ? n - 1 - k : k;
        word = big_t'((tap_of(d, k) >> (c*w)) & ((64'd1 << w) - 64'd1));
        bus_v |= word << ((c*n + j)*w);
      end
    end
    return bus_v;
  endfunction

  function automatic int exp_fill(input int d);
    return (cnt[d] < geo_n(d)) ? cnt[d] : geo_n(d);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; od[d] = '0; ov[d] = 1'b0;
    end
  endtask

  // apply one rising edge to the model using the inputs currently driven
  task automatic model_edge();
    vec_t din;
    int   se;
    for (int d = 0; d < 2; d++) begin
      din = (d == 0) ? vec_t'(data_a) : vec_t'(data_b);
      if (rst || clr) begin
        cnt[d] = 0; od[d] = '0; ov[d] = 1'b0;
      end else if (in_valid) begin
        samp[d][cnt[d]] = din;
        cnt[d]++;
        se = (int'(sel) > geo_n(d) - 1) ? geo_n(d) - 1 : int'(sel);
        od[d] = tap_of(d, se);
        ov[d] = (exp_fill(d) > se);
      end else begin
        ov[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("a.taps",  big_t'(if_a.taps),      exp_taps(0));
    check("a.data",  big_t'(if_a.out_data),  big_t'(od[0]));
    check("a.valid", big_t'(if_a.out_valid), big_t'(ov[0]));
    check("a.fill",  big_t'(if_a.fill),      big_t'(exp_fill(0)));
    check("a.full",  big_t'(if_a.full),      big_t'(cnt[0] >= NA));
    check("b.taps",  big_t'(if_b.taps),      exp_taps(1));
    check("b.data",  big_t'(if_b.out_data),  big_t'(od[1]));
    check("b.valid", big_t'(if_b.out_valid), big_t'(ov[1]));
    check("b.fill",  big_t'(if_b.fill),      big_t'(exp_fill(1)));
    check("b.full",  big_t'(if_b.full),      big_t'(cnt[1] >= NB));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // channel c carries (c+1)*100 + n
  task automatic set_data(input int n);
    for (int c = 0; c < CA; c++) data_a[c*WA +: WA] = WA'((c + 1)*100 + n);
    for (int c = 0; c < CB; c++) data_b[c*WB +: WB] = WB'((c + 1)*100 + n);
  endtask

  task automatic stream(input logic [2:0] s, input int count);
    sel = s;
    for (int i = 1; i <= count; i++) begin
      in_valid = 1'b1; set_data(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1; in_valid = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    stream(3'd0, 10);           // fill and saturation
    do_clear();
    stream(3'd5, 12);           // 5-sample delay on a, clamped to 4 on b
    do_clear();
    stream(3'd7, 8);            // oldest tap / clamp, tap-bus order

    // gapped multi-channel stream
    do_clear();
    sel = 3'd2;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i % 2 == 0); set_data(i + 1);
      tick();
    end

    // clear wins over a simultaneous sample
    stream(3'd1, 9);
    clr = 1'b1; in_valid = 1'b1;
    data_a = {CA{16'hAAAA}}; data_b = {CB{12'hAAA}};
    tick();
    clr = 1'b0; set_data(42);
    tick();
    in_valid = 1'b0;
    tick();

    // async reset between edges while full
    stream(3'd3, 9);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    @(negedge clk);
    rst = 1'b0;
    stream(3'd0, 3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      sel      = 3'($urandom);
      data_a   = {$urandom, $urandom};
      data_b   = 24'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tap_delay_line.md
# tap_delay_line

Multi-channel, parametrised tap delay line for the LMS datapath, generalising the single-channel shift register. It holds the last N samples of CH parallel channels, exposes every tap in parallel for the FIR/LMS multiply-accumulate stage, and provides a registered, runtime-selectable delayed output with a valid flag. Sample fill tracking suppresses output validity until the selected tap holds real data.

## Interface
- N, 8: taps per channel (delay depth); integer ≥ 2
- W, 16: sample width in bits; integer ≥ 1
- CH, 1: number of channels, all shifted together; integer ≥ 1
- DIR, 0: tap bus ordering; 0 = tap 0 (newest) in lowest word of each channel, 1 = tap 0 in highest word
- Derived: SW = max(1, clog2(N)); FW = clog2(N+1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of taps, fill count and outputs
- in_valid  in  1  shift strobe; one sample per channel accepted per cycle when high
- in_data  in  CH*W  channel c at in_data[c*W +: W]
- sel  in  SW  selected delay tap for out_data, sampled when in_valid = 1
- taps  out  CH*N*W  all tap registers; channel c, word j at taps[(c*N + j)*W +: W]; j = k (DIR=0) or N-1-k (DIR=1) for tap k
- out_data  out  CH*W  registered tap[sel] per channel
- out_valid  out  1  out_data holds a real delayed sample, one-cycle pulse per accepted input
- fill  out  FW  number of samples shifted in since reset/clear, saturating at N
- full  out  1  fill == N

## Operation
- Tap k of a channel = sample accepted k shifts ago after the current shift; tap 0 = newest.
- Shift (in_valid=1, clr=0): per channel, tap k ← tap k-1 for k = N-1..1, tap 0 ← in_data word; tap N-1 old contents discarded. in_valid=0: taps hold.
- sel clamp: sel_eff = min(sel, N-1); out-of-range sel never indexes outside the array.
- On a shift: out_data ← new tap[sel_eff] per channel (sel_eff=0 gives the incoming sample); fill ← min(fill+1, N); out_valid ← 1 only if new fill > sel_eff, else 0.
- No shift: out_valid ← 0; out_data holds; fill holds.
- clr: taps, out_data, fill, out_valid ← 0 on the next edge; clr has priority over a simultaneous in_valid (sample dropped, not counted).
- All channels share in_valid, sel, fill and out_valid.
- No backpressure; sink must accept every out_valid pulse.

## Timing
- Reset values (async assert, held while rst=1): taps = 0, out_data = 0, out_valid = 0, fill = 0, full = 0.
- Latency: in_valid at edge t → taps, out_data, out_valid, fill visible after edge t; 1-cycle registered.
- full is combinational from the fill register, no extra latency.
- Back-to-back in_valid: one shift per cycle, full throughput.
- fill saturates at N; further shifts keep full = 1 and fill = N.
- sel changes take effect only on cycles with in_valid = 1.
- rst deassertion: first in_valid after release is treated as the first sample (fill becomes 1).

## Test plan
- Reset/fill: N=8, CH=1, W=16, sel=0; drive in_valid with 1..10 back-to-back -> out_data 1..10 one cycle later, out_valid high each cycle, fill 1..8 then stays 8, full asserts after 8th sample.
- Delay select: N=8, sel=5, inputs 1..12 -> out_valid low for the first 5 samples, then out_data = 1,2,…,7 on samples 6..12 (exactly 5-sample delay).
- Clamp and tap bus: sel=15, N=8 -> behaves as sel=7; after inputs 1..8, taps channel 0 words 0..7 = 8,7,…,1 with DIR=0 and 1,…,8 with DIR=1.
- Multi-channel gapped: CH=3, in_data = {c3,c2,c1} with c = 100,200,300 + n, in_valid toggling 1/0 -> taps shift only on valid cycles, out_valid pulses only after valid cycles, channels never mix.
- Clear priority: after full, assert clr with in_valid=1, data 0xAAAA -> next cycle all taps 0, fill 0, out_valid 0, sample not stored; next valid sample gives fill 1.
- Async reset mid-stream: assert rst between clock edges while full -> all outputs 0 immediately, no edge needed; operation restarts cleanly after release.
